// File: rtl/lc3_writeback_pkg.sv
// ============================================================================
// Module : lc3_wb_pkg
// Brief  : Shared types, constants and PSR helper for the LC3 writeback stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lc3_wb_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_PC   = 2'd1,
        WB_MEM  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_t;

    localparam logic [2:0] PSR_N = 3'b100;
    localparam logic [2:0] PSR_Z = 3'b010;
    localparam logic [2:0] PSR_P = 3'b001;

    // Negative takes priority; zero only when every bit is clear.
    function automatic logic [2:0] calc_psr(input logic [15:0] value);
        if (value[15])
            return PSR_N;
        else if (value == 16'h0000)
            return PSR_Z;
        else
            return PSR_P;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lc3_writeback_if.sv
// ============================================================================
// Module : lc3_writeback_if
// Brief  : writeback_in bus between execute/memaccess (master) and writeback.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface lc3_writeback_if;
    import lc3_wb_pkg::*;

    logic [DATA_W-1:0] aluout;
    logic [1:0]        W_Control;
    logic [DATA_W-1:0] pcout;
    logic [DATA_W-1:0] memout;
    logic              enable_writeback;
    logic [REG_AW-1:0] sr1;
    logic [REG_AW-1:0] sr2;
    logic [REG_AW-1:0] dr;
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] VSR1;
    logic [DATA_W-1:0] VSR2;
    logic [2:0]        psr;
    logic [DATA_W-1:0] last_npc;
    logic              wb_illegal;

    modport master (
        output aluout, W_Control, pcout, memout, enable_writeback,
        output sr1, sr2, dr, npc,
        input  VSR1, VSR2, psr, last_npc, wb_illegal
    );

    modport slave (
        input  aluout, W_Control, pcout, memout, enable_writeback,
        input  sr1, sr2, dr, npc,
        output VSR1, VSR2, psr, last_npc, wb_illegal
    );

endinterface

`default_nettype wire

// File: rtl/lc3_writeback_regfile.sv
// ============================================================================
// Module : lc3_regfile
// Brief  : NUM_REGS x DATA_W register file, 1 sync write, 2 async reads.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lc3_regfile #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              we_i,
    input  wire logic [AW-1:0]     waddr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    input  wire logic [AW-1:0]     raddr1_i,
    input  wire logic [AW-1:0]     raddr2_i,
    output logic      [DATA_W-1:0] rdata1_o,
    output logic      [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // No bypass: a read of the address being written returns the old value.
    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

`default_nettype wire

// File: rtl/lc3_writeback.sv
// ============================================================================
// Module : lc3_writeback
// Brief  : LC3 writeback stage: source mux, regfile write, PSR and debug flops.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lc3_writeback
    import lc3_wb_pkg::*;
(
    input  wire logic         clock,
    input  wire logic         reset,
    lc3_writeback_if.slave    wb
);

    wb_sel_t           w_sel;
    logic [DATA_W-1:0] w_wdata;
    logic              w_write;
    logic              w_illegal;

    logic [2:0]        psr_q, psr_d;
    logic [DATA_W-1:0] last_npc_q, last_npc_d;
    logic              illegal_q, illegal_d;

    assign w_sel = wb_sel_t'(wb.W_Control);

    always_comb begin
        w_wdata = '0;
        case (w_sel)
            WB_ALU:  w_wdata = wb.aluout;
            WB_PC:   w_wdata = wb.pcout;
            WB_MEM:  w_wdata = wb.memout;
            default: w_wdata = '0;
        endcase
    end

    // Enable gates everything, so X/Z on other inputs cannot reach state.
    assign w_write   = wb.enable_writeback && (w_sel != WB_RSVD);
    assign w_illegal = wb.enable_writeback && (w_sel == WB_RSVD);

    always_comb begin
        psr_d      = psr_q;
        last_npc_d = last_npc_q;
        illegal_d  = w_illegal;
        if (w_write) begin
            psr_d      = calc_psr(w_wdata);
            last_npc_d = wb.npc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            psr_q      <= 3'b000;
            last_npc_q <= '0;
            illegal_q  <= 1'b0;
        end else begin
            psr_q      <= psr_d;
            last_npc_q <= last_npc_d;
            illegal_q  <= illegal_d;
        end
    end

    lc3_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .AW       (REG_AW)
    ) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .we_i     (w_write),
        .waddr_i  (wb.dr),
        .wdata_i  (w_wdata),
        .raddr1_i (wb.sr1),
        .raddr2_i (wb.sr2),
        .rdata1_o (wb.VSR1),
        .rdata2_o (wb.VSR2)
    );

    assign wb.psr        = psr_q;
    assign wb.last_npc   = last_npc_q;
    assign wb.wb_illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_lc3_writeback.sv
// ============================================================================
// Module : tb_lc3_writeback
// Brief  : Directed self-checking bench for the LC3 writeback stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_lc3_writeback;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    lc3_writeback_if wb_bus ();

    lc3_writeback dut (
        .clock (clock),
        .reset (reset),
        .wb    (wb_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic [1:0] wc, input logic [2:0] dst,
                         input logic [15:0] alu, input logic [15:0] pc,
                         input logic [15:0] mem, input logic [15:0] np);
        wb_bus.enable_writeback = en;
        wb_bus.W_Control        = wc;
        wb_bus.dr               = dst;
        wb_bus.aluout           = alu;
        wb_bus.pcout            = pc;
        wb_bus.memout           = mem;
        wb_bus.npc              = np;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
        wb_bus.sr1 = 3'd0;
        wb_bus.sr2 = 3'd0;
        #2;
        vectors++;
        if (wb_bus.psr !== 3'b000 || wb_bus.last_npc !== 16'h0000 || wb_bus.wb_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flops: psr=%b last_npc=%h ill=%b, want 000 0000 0", wb_bus.psr,
                     wb_bus.last_npc, wb_bus.wb_illegal);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_alu_write();
        drive(1'b1, 2'd0, 3'd3, 16'h8001, 16'h0, 16'h0, 16'h3001);
        wb_bus.sr1 = 3'd3;
        #1;
        vectors++;
        if (wb_bus.VSR1 !== 16'h0000) begin
            miscompares++;
            $display("FAIL alu_old_value: VSR1=%h want 0000", wb_bus.VSR1);
        end
        tick();
        wb_bus.enable_writeback = 1'b0;
        #1;
        vectors++;
        if (wb_bus.VSR1 !== 16'h8001 || wb_bus.psr !== 3'b100 || wb_bus.last_npc !== 16'h3001) begin
            miscompares++;
            $display("FAIL alu_write: VSR1=%h psr=%b npc=%h want 8001 100 3001", wb_bus.VSR1,
                     wb_bus.psr, wb_bus.last_npc);
        end
    endtask

    task automatic test_src_sweep();
        drive(1'b1, 2'd1, 3'd5, 16'hAAAA, 16'h3000, 16'hBBBB, 16'h3002);
        tick();
        wb_bus.enable_writeback = 1'b0;
        wb_bus.sr1 = 3'd5;
        #1;
        vectors++;
        if (wb_bus.VSR1 !== 16'h3000 || wb_bus.psr !== 3'b001 || wb_bus.last_npc !== 16'h3002) begin
            miscompares++;
            $display("FAIL src_pc: VSR1=%h psr=%b npc=%h want 3000 001 3002", wb_bus.VSR1,
                     wb_bus.psr, wb_bus.last_npc);
        end
        drive(1'b1, 2'd2, 3'd6, 16'h5555, 16'h7777, 16'h0000, 16'h3003);
        tick();
        wb_bus.enable_writeback = 1'b0;
        wb_bus.sr1 = 3'd6;
        #1;
        vectors++;
        if (wb_bus.VSR1 !== 16'h0000 || wb_bus.psr !== 3'b010 || wb_bus.last_npc !== 16'h3003) begin
            miscompares++;
            $display("FAIL src_mem: VSR1=%h psr=%b npc=%h want 0000 010 3003", wb_bus.VSR1,
                     wb_bus.psr, wb_bus.last_npc);
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 2'd0, 3'd3, 16'hFFFF, 16'h0, 16'h0, 16'h9999);
        tick();
        wb_bus.aluout    = 16'hxxxx;
        wb_bus.W_Control = 2'bxx;
        wb_bus.dr        = 3'bxxx;
        wb_bus.npc       = 16'hxxxx;
        tick();
        wb_bus.sr1 = 3'd3;
        #1;
        vectors++;
        if (wb_bus.VSR1 !== 16'h8001 || wb_bus.psr !== 3'b010 || wb_bus.last_npc !== 16'h3003
            || wb_bus.wb_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL hold: VSR1=%h psr=%b npc=%h ill=%b want 8001 010 3003 0", wb_bus.VSR1,
                     wb_bus.psr, wb_bus.last_npc, wb_bus.wb_illegal);
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 2'd3, 3'd2, 16'h1234, 16'h1234, 16'h1234, 16'h4444);
        wb_bus.sr1 = 3'd2;
        tick();
        wb_bus.enable_writeback = 1'b0;
        wb_bus.W_Control        = 2'd0;
        #1;
        vectors++;
        if (wb_bus.wb_illegal !== 1'b1 || wb_bus.VSR1 !== 16'h0000 || wb_bus.psr !== 3'b010
            || wb_bus.last_npc !== 16'h3003) begin
            miscompares++;
            $display("FAIL illegal_pulse: ill=%b VSR1=%h psr=%b npc=%h want 1 0000 010 3003",
                     wb_bus.wb_illegal, wb_bus.VSR1, wb_bus.psr, wb_bus.last_npc);
        end
        tick();
        vectors++;
        if (wb_bus.wb_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_one_cycle: ill=%b want 0", wb_bus.wb_illegal);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'd0, 3'd7, 16'h0001, 16'h0, 16'h0, 16'h5001);
        wb_bus.sr1 = 3'd7;
        wb_bus.sr2 = 3'd7;
        tick();
        vectors++;
        if (wb_bus.VSR1 !== 16'h0001 || wb_bus.psr !== 3'b001) begin
            miscompares++;
            $display("FAIL b2b_first: VSR1=%h psr=%b want 0001 001", wb_bus.VSR1, wb_bus.psr);
        end
        drive(1'b1, 2'd0, 3'd7, 16'hFFFE, 16'h0, 16'h0, 16'h5002);
        tick();
        wb_bus.enable_writeback = 1'b0;
        #1;
        vectors++;
        if (wb_bus.VSR1 !== 16'hFFFE || wb_bus.VSR2 !== 16'hFFFE || wb_bus.psr !== 3'b100
            || wb_bus.last_npc !== 16'h5002) begin
            miscompares++;
            $display("FAIL b2b_second: VSR1=%h VSR2=%h psr=%b npc=%h want FFFE FFFE 100 5002",
                     wb_bus.VSR1, wb_bus.VSR2, wb_bus.psr, wb_bus.last_npc);
        end
    endtask

    task automatic test_all_regs();
        logic [15:0] exp_v;
        for (int r = 0; r < 8; r++) begin
            exp_v = 16'h1111 * r[15:0] + 16'h0010;
            drive(1'b1, 2'd0, r[2:0], exp_v, 16'h0, 16'h0, 16'h6000 + r[15:0]);
            tick();
        end
        wb_bus.enable_writeback = 1'b0;
        for (int r = 0; r < 8; r++) begin
            exp_v = 16'h1111 * r[15:0] + 16'h0010;
            wb_bus.sr1 = r[2:0];
            wb_bus.sr2 = 3'(7 - r);
            #1;
            vectors++;
            if (wb_bus.VSR1 !== exp_v) begin
                miscompares++;
                $display("FAIL all_regs_r%0d: VSR1=%h want %h", r, wb_bus.VSR1, exp_v);
            end
            exp_v = 16'h1111 * 16'(7 - r) + 16'h0010;
            vectors++;
            if (wb_bus.VSR2 !== exp_v) begin
                miscompares++;
                $display("FAIL all_regs_sr2_%0d: VSR2=%h want %h", 7 - r, wb_bus.VSR2, exp_v);
            end
        end
        // R7 = 7*1111+10 = 7787 is positive.
        vectors++;
        if (wb_bus.psr !== 3'b001 || wb_bus.last_npc !== 16'h6007) begin
            miscompares++;
            $display("FAIL all_regs_flags: psr=%b npc=%h want 001 6007", wb_bus.psr, wb_bus.last_npc);
        end
    endtask

    task automatic test_reset_midrun();
        drive(1'b1, 2'd3, 3'd1, 16'h2222, 16'h0, 16'h0, 16'h7000);
        tick();
        drive(1'b1, 2'd0, 3'd1, 16'h2222, 16'h0, 16'h0, 16'h7001);
        #2;
        reset = 1'b0;
        #1;
        for (int r = 0; r < 8; r++) begin
            wb_bus.sr1 = r[2:0];
            wb_bus.sr2 = r[2:0];
            #1;
            vectors++;
            if (wb_bus.VSR1 !== 16'h0000 || wb_bus.VSR2 !== 16'h0000) begin
                miscompares++;
                $display("FAIL midrun_reset_r%0d: VSR1=%h VSR2=%h want 0000", r, wb_bus.VSR1,
                         wb_bus.VSR2);
            end
        end
        vectors++;
        if (wb_bus.psr !== 3'b000 || wb_bus.last_npc !== 16'h0000 || wb_bus.wb_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_reset_flops: psr=%b npc=%h ill=%b want 000 0000 0", wb_bus.psr,
                     wb_bus.last_npc, wb_bus.wb_illegal);
        end
        tick();
        wb_bus.sr1 = 3'd1;
        #1;
        vectors++;
        if (wb_bus.VSR1 !== 16'h0000 || wb_bus.psr !== 3'b000) begin
            miscompares++;
            $display("FAIL write_in_reset: VSR1=%h psr=%b want 0000 000", wb_bus.VSR1, wb_bus.psr);
        end
        wb_bus.enable_writeback = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_alu_write();
        test_src_sweep();
        test_hold();
        test_illegal();
        test_back_to_back();
        test_all_regs();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
